// File: rtl/transient_shaper_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : transient_shaper_pkg
//  Description : Shared FSM state type, gain constants and saturation helper
//                for the multi-channel transient shaper.
//  Revision    : 1.0 - initial release
// ============================================================================
package transient_shaper_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int GAIN_UNITY = 4;
    localparam int GAIN_FRAC  = 2;

    // Clamp a signed value to the range of a w-bit two's complement number.
    function automatic logic signed [31:0] sat(input logic signed [31:0] v, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/envelope_follower.sv
`default_nettype none
// ============================================================================
//  Module      : envelope_follower
//  Description : Combinational fast/slow envelope update and attack detect,
//                time-shared across channels by the shaper top level.
//  Revision    : 1.0 - initial release
// ============================================================================
module envelope_follower
    import transient_shaper_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int FAST_SHIFT = 2,
    parameter int SLOW_SHIFT = 6,
    parameter int THRESH     = 2
) (
    input  logic [WIDTH-2:0]            i_rect,
    input  logic [WIDTH+SLOW_SHIFT-2:0] i_fast,
    input  logic [WIDTH+SLOW_SHIFT-2:0] i_slow,
    output logic [WIDTH+SLOW_SHIFT-2:0] o_fast,
    output logic [WIDTH+SLOW_SHIFT-2:0] o_slow,
    output logic                        o_attack
);

    localparam int               c_env_w  = WIDTH - 1 + SLOW_SHIFT;
    localparam logic [WIDTH:0]   c_thresh = (WIDTH + 1)'(THRESH);

    logic signed [c_env_w:0] w_r;
    logic signed [c_env_w:0] w_fast;
    logic signed [c_env_w:0] w_slow;
    logic signed [c_env_w:0] w_fast_d;
    logic signed [c_env_w:0] w_slow_d;
    logic        [WIDTH:0]   w_si_th;

    // Rectified sample scaled into the envelope's fixed-point format.
    assign w_r      = $signed({1'b0, i_rect, {SLOW_SHIFT{1'b0}}});
    assign w_fast   = $signed({1'b0, i_fast});
    assign w_slow   = $signed({1'b0, i_slow});
    assign w_fast_d = w_r - w_fast;
    assign w_slow_d = w_r - w_slow;

    // Results stay between old value and target, so they always fit unsigned.
    assign o_fast = c_env_w'(w_fast + (w_fast_d >>> FAST_SHIFT));
    assign o_slow = c_env_w'(w_slow + (w_slow_d >>> SLOW_SHIFT));

    assign w_si_th  = {2'b00, o_slow[c_env_w-1:SLOW_SHIFT]} + c_thresh;
    assign o_attack = ({2'b00, o_fast[c_env_w-1:SLOW_SHIFT]} > w_si_th);

endmodule
`default_nettype wire

// File: rtl/transient_shaper_mc.sv
`default_nettype none
// ============================================================================
//  Module      : transient_shaper_mc
//  Description : Multi-channel transient shaper; one shared datapath walks the
//                channels of each accepted frame, then publishes the result.
//  Revision    : 1.0 - initial release
// ============================================================================
module transient_shaper_mc
    import transient_shaper_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int CHANNELS   = 2,
    parameter int GAIN_BITS  = 3,
    parameter int FAST_SHIFT = 2,
    parameter int SLOW_SHIFT = 6,
    parameter int THRESH     = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ena,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CHANNELS*WIDTH-1:0]   audio_in,
    input  logic [GAIN_BITS-1:0]        attack_amt,
    input  logic [GAIN_BITS-1:0]        sustain_amt,
    output logic [CHANNELS*WIDTH-1:0]   audio_out,
    output logic                        out_valid,
    output logic [CHANNELS-1:0]         transient
);

    localparam int                c_env_w   = WIDTH - 1 + SLOW_SHIFT;
    localparam int                c_ch_w    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [c_ch_w-1:0] c_last_ch = c_ch_w'(CHANNELS - 1);
    localparam int                c_prod_w  = WIDTH + GAIN_BITS + 1;

    state_t                       r_state;
    state_t                       w_state_next;
    logic [c_ch_w-1:0]            r_ch;
    logic [CHANNELS*WIDTH-1:0]    r_frame;
    logic [CHANNELS*WIDTH-1:0]    r_work;
    logic [CHANNELS*WIDTH-1:0]    w_work_next;
    logic [CHANNELS-1:0]          r_work_tr;
    logic [CHANNELS-1:0]          w_tr_next;
    logic [GAIN_BITS-1:0]         r_att;
    logic [GAIN_BITS-1:0]         r_sus;
    logic                         r_ena;
    logic [c_env_w-1:0]           r_fast [CHANNELS];
    logic [c_env_w-1:0]           r_slow [CHANNELS];

    logic                         w_accept;
    logic                         w_last;
    logic signed [WIDTH-1:0]      w_x;
    logic [WIDTH-2:0]             w_rect;
    logic [c_env_w-1:0]           w_fast_new;
    logic [c_env_w-1:0]           w_slow_new;
    logic                         w_attack;
    logic                         w_phase;
    logic [GAIN_BITS-1:0]         w_gain;
    logic signed [c_prod_w-1:0]   w_prod;
    logic signed [WIDTH-1:0]      w_y_gain;
    logic signed [WIDTH-1:0]      w_y;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign w_last = (r_ch == c_last_ch);

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                out_valid    = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------- datapath
    assign w_x = r_frame[r_ch*WIDTH +: WIDTH];

    // Magnitude in WIDTH-1 bits; the most negative code has no positive twin.
    always_comb begin
        w_rect = w_x[WIDTH-2:0];
        if (w_x[WIDTH-1]) begin
            if (w_x[WIDTH-2:0] == '0) begin
                w_rect = '1;
            end else begin
                w_rect = ~w_x[WIDTH-2:0] + (WIDTH - 1)'(1);
            end
        end
    end

    envelope_follower #(
        .WIDTH      (WIDTH),
        .FAST_SHIFT (FAST_SHIFT),
        .SLOW_SHIFT (SLOW_SHIFT),
        .THRESH     (THRESH)
    ) u_env (
        .i_rect   (w_rect),
        .i_fast   (r_fast[r_ch]),
        .i_slow   (r_slow[r_ch]),
        .o_fast   (w_fast_new),
        .o_slow   (w_slow_new),
        .o_attack (w_attack)
    );

    assign w_phase  = w_attack & r_ena;
    assign w_gain   = w_phase ? r_att : r_sus;
    assign w_prod   = c_prod_w'(w_x) * c_prod_w'($signed({1'b0, w_gain}));
    assign w_y_gain = WIDTH'(sat(32'(w_prod >>> GAIN_FRAC), WIDTH));
    assign w_y      = r_ena ? w_y_gain : w_x;

    always_comb begin
        w_work_next                        = r_work;
        w_work_next[r_ch*WIDTH +: WIDTH]   = w_y;
        w_tr_next                          = r_work_tr;
        w_tr_next[r_ch]                    = w_phase;
    end

    // Output register loads on the last channel so it is visible during DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ch      <= '0;
            r_frame   <= '0;
            r_work    <= '0;
            r_work_tr <= '0;
            r_att     <= '0;
            r_sus     <= '0;
            r_ena     <= 1'b0;
            audio_out <= '0;
            transient <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_fast[c] <= '0;
                r_slow[c] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_frame <= audio_in;
                r_att   <= attack_amt;
                r_sus   <= sustain_amt;
                r_ena   <= ena;
                r_ch    <= '0;
            end
            if (r_state == RUN) begin
                r_work    <= w_work_next;
                r_work_tr <= w_tr_next;
                if (r_ena) begin
                    r_fast[r_ch] <= w_fast_new;
                    r_slow[r_ch] <= w_slow_new;
                end
                if (w_last) begin
                    audio_out <= w_work_next;
                    transient <= w_tr_next;
                end else begin
                    r_ch <= r_ch + c_ch_w'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_transient_shaper_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_transient_shaper_mc
//  Description : Self-checking bench for transient_shaper_mc with a frame-level
//                reference model and directed literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_transient_shaper_mc;

    localparam int W  = 8;
    localparam int CH = 2;
    localparam int GB = 3;
    localparam int FS = 2;
    localparam int SS = 6;
    localparam int TH = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ena = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [CH*W-1:0] audio_in = '0;
    logic [GB-1:0]   attack_amt = 3'd4;
    logic [GB-1:0]   sustain_amt = 3'd4;
    logic [CH*W-1:0] audio_out;
    logic            out_valid;
    logic [CH-1:0]   transient;

    transient_shaper_mc #(
        .WIDTH(W), .CHANNELS(CH), .GAIN_BITS(GB),
        .FAST_SHIFT(FS), .SLOW_SHIFT(SS), .THRESH(TH)
    ) dut (
        .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
        .audio_in(audio_in), .attack_amt(attack_amt), .sustain_amt(sustain_amt),
        .audio_out(audio_out), .out_valid(out_valid), .transient(transient)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference state: envelopes per channel and the externally visible outputs.
    int              m_fast [CH];
    int              m_slow [CH];
    int              m_cnt = 0;
    bit              m_ready = 1'b1;
    bit              m_valid = 1'b0;
    bit              chk_en = 1'b0;
    logic [CH*W-1:0] exp_out = '0;
    logic [CH*W-1:0] pend_out = '0;
    logic [CH-1:0]   exp_tr = '0;
    logic [CH-1:0]   pend_tr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_total++;
        $display("FAIL %s: got timeout expected event at t=%0t", name, $time);
    endtask

    function automatic int fdiv(input int a, input int sh);
        int d;
        d = 1 << sh;
        if (a >= 0) return a / d;
        return -((-a + d - 1) / d);
    endfunction

    task automatic model_frame(input logic [CH*W-1:0] d, input logic [GB-1:0] a,
                               input logic [GB-1:0] s, input logic e);
        for (int c = 0; c < CH; c++) begin
            logic signed [W-1:0] xs;
            int x, rect, y, g;
            bit t;
            xs = d[c*W +: W];
            x  = xs;
            t  = 1'b0;
            y  = x;
            if (e) begin
                rect = (x < 0) ? -x : x;
                if (rect > (1 << (W - 1)) - 1) rect = (1 << (W - 1)) - 1;
                m_fast[c] = m_fast[c] + fdiv(rect * (1 << SS) - m_fast[c], FS);
                m_slow[c] = m_slow[c] + fdiv(rect * (1 << SS) - m_slow[c], SS);
                t = (m_fast[c] / (1 << SS)) > (m_slow[c] / (1 << SS)) + TH;
                g = t ? int'(a) : int'(s);
                y = fdiv(x * g, 2);
                if (y > (1 << (W - 1)) - 1) y = (1 << (W - 1)) - 1;
                if (y < -(1 << (W - 1)))    y = -(1 << (W - 1));
            end
            pend_out[c*W +: W] = y[W-1:0];
            pend_tr[c]         = t;
        end
    endtask

    // Frame-level model advanced on every active edge.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                for (int c = 0; c < CH; c++) begin
                    m_fast[c] = 0;
                    m_slow[c] = 0;
                end
                m_cnt   = 0;
                exp_out = '0;
                exp_tr  = '0;
                chk_en  = 1'b1;
            end else begin
                if (m_cnt == 0 && in_valid) begin
                    model_frame(audio_in, attack_amt, sustain_amt, ena);
                    m_cnt = CH + 1;
                end else if (m_cnt > 0) begin
                    m_cnt--;
                end
                if (m_cnt == 1) begin
                    exp_out = pend_out;
                    exp_tr  = pend_tr;
                end
            end
            m_ready = (m_cnt == 0);
            m_valid = (m_cnt == 1);
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("in_ready",  32'(in_ready),  32'(m_ready));
                check("out_valid", 32'(out_valid), 32'(m_valid));
                check("audio_out", 32'(audio_out), 32'(exp_out));
                check("transient", 32'(transient), 32'(exp_tr));
            end
        end
    end

    task automatic drive_frame(input logic [CH*W-1:0] d, input logic [GB-1:0] a,
                               input logic [GB-1:0] s, input logic e);
        int guard;
        guard = 0;
        while (!m_ready) begin
            @(posedge clk);
            #1;
            guard++;
            if (guard > 20) begin
                fail_timeout("ready_wait");
                return;
            end
        end
        audio_in    = d;
        attack_amt  = a;
        sustain_amt = s;
        ena         = e;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                n = i;
                return;
            end
        end
        fail_timeout("out_valid_wait");
    endtask

    task automatic count_valid(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) cnt++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish at t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int cnt;
        do_reset();
        @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_audio_out", 32'(audio_out), 32'd0);
        check("rst_transient", 32'(transient), 32'd0);
        @(posedge clk);
        #1;

        // Unity gain and latency.
        drive_frame({8'hC0, 8'h40}, 3'd4, 3'd4, 1'b1);
        wait_valid(n);
        check("latency", 32'(n), 32'd3);
        check("unity_out", 32'(audio_out), 32'h0000C040);
        idle(2);

        // Fresh envelopes: both channels attack and saturate.
        do_reset();
        drive_frame({8'h80, 8'd100}, 3'd7, 3'd4, 1'b1);
        wait_valid(n);
        check("attack_sat_out", 32'(audio_out), 32'h0000807F);
        check("attack_sat_tr",  32'(transient), 32'd3);
        idle(2);

        // Long steady tone settles into the sustain phase.
        for (int i = 0; i < 2000; i++) begin
            drive_frame({8'h00, 8'd100}, 3'd7, 3'd2, 1'b1);
        end
        wait_valid(n);
        check("steady_out0", 32'(audio_out[7:0]), 32'd50);
        check("steady_tr0",  32'(transient[0]),   32'd0);
        drive_frame({8'h00, 8'h00}, 3'd7, 3'd2, 1'b1);
        wait_valid(n);
        check("decay_out0", 32'(audio_out[7:0]), 32'd0);
        check("decay_tr0",  32'(transient[0]),   32'd0);
        idle(2);

        // Second strobe while busy is dropped.
        drive_frame({8'h11, 8'h22}, 3'd5, 3'd3, 1'b1);
        audio_in = {8'h7F, 8'h7F};
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        count_valid(8, cnt);
        check("busy_drop_pulses", 32'(cnt), 32'd1);
        @(posedge clk);
        #1;

        // Bypass passes the frame through untouched.
        drive_frame({8'h9C, 8'h33}, 3'd7, 3'd0, 1'b0);
        wait_valid(n);
        check("bypass_out", 32'(audio_out), 32'h00009C33);
        check("bypass_tr",  32'(transient), 32'd0);
        idle(2);
        drive_frame({8'hA5, 8'h5A}, 3'd6, 3'd3, 1'b1);
        idle(6);

        // Reset one cycle after acceptance aborts the frame.
        drive_frame({8'h80, 8'd100}, 3'd7, 3'd4, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        count_valid(6, cnt);
        check("abort_pulses", 32'(cnt), 32'd0);
        @(posedge clk);
        #1;
        drive_frame({8'h80, 8'd100}, 3'd7, 3'd4, 1'b1);
        wait_valid(n);
        check("after_abort_out", 32'(audio_out), 32'h0000807F);
        check("after_abort_tr",  32'(transient), 32'd3);
        idle(2);

        // Reset and strobe together: reset wins.
        rst      = 1'b1;
        in_valid = 1'b1;
        audio_in = {8'h40, 8'h40};
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        count_valid(6, cnt);
        check("rst_with_valid_pulses", 32'(cnt), 32'd0);
        @(posedge clk);
        #1;

        // Randomized frames with busy strobes, mid-frame input churn, rare resets.
        for (int i = 0; i < 300; i++) begin
            drive_frame(CH*W'($urandom), GB'($urandom_range(0, 7)), GB'($urandom_range(0, 7)),
                        ($urandom_range(0, 9) != 0));
            if ($urandom_range(0, 3) == 0) begin
                audio_in = CH*W'($urandom);
                in_valid = 1'b1;
                @(posedge clk);
                #1;
                in_valid = 1'b0;
            end
            audio_in    = CH*W'($urandom);
            attack_amt  = GB'($urandom);
            sustain_amt = GB'($urandom);
            ena         = 1'($urandom);
            if ($urandom_range(0, 49) == 0) begin
                do_reset();
            end
            idle($urandom_range(0, 3));
        end
        idle(8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
